vbuf_feed_ctrl: RTL
===================

# vbuf_feed_ctrl

Sequencer for the systolic array's vertical ifmap buffer, a per-column 4-deep shift FIFO with no stall input. It accepts one ifmap layer as a stream of rows over a valid/ready interface and drives the buffer's data and enable inputs. It produces a valid flag cycle-aligned with the buffer output, drains the pipeline after the last row, waits out the PE array latency, and then signals layer completion so the next layer can start.

## Interface
Parameters:
- COL_NUM, 32, number of array columns.
- DATA_W, 8, bits per column element.
- BUF_DEPTH, 4, latency of the vertical buffer in cycles.
- ROW_CNT_W, 16, width of the row counter and `num_rows`.
- DRAIN_W, 8, width of `pe_drain_cycles`.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle layer start; sampled only in IDLE.
- num_rows  input  ROW_CNT_W  rows in the layer; captured on `start`.
- pe_drain_cycles  input  DRAIN_W  extra PE latency after the buffer drains; captured on `start`.
- src_valid  input  1  upstream row valid.
- src_ready  output  1  controller accepts a row.
- src_data  input  COL_NUM*DATA_W  upstream row.
- vb_ifmap_in  output  COL_NUM*DATA_W  to the buffer's data input.
- vb_ifmap_en  output  1  to the buffer's enable input.
- vb_out_valid  output  1  buffer output holds a real row this cycle.
- busy  output  1  high from the cycle after `start` until `done`.
- done  output  1  one-cycle layer-complete pulse.
- rows_sent  output  ROW_CNT_W  rows accepted in the current layer.

## Operation
- States: IDLE, STREAM, DRAIN, PE_WAIT, DONE.
- IDLE:
  - On `start`, capture `num_rows` and `pe_drain_cycles` and clear `rows_sent`.
  - Go to STREAM, or to DONE if `num_rows`==0.
- STREAM:
  - `src_ready`=1.
  - An accepted row (`src_valid`&&`src_ready`) sets `vb_ifmap_en`=1 combinationally and increments `rows_sent`.
  - `vb_ifmap_in`=`src_data` combinationally.
  - When `src_valid`=0, `vb_ifmap_en`=0; the buffer shifts in a zero bubble.
  - The accepted row that makes `rows_sent`==`num_rows` moves the block to DRAIN.
- DRAIN:
  - `src_ready`=0 and `vb_ifmap_en`=0.
  - Lasts exactly BUF_DEPTH cycles, counted by a down-counter.
  - Then go to PE_WAIT, or to DONE if the captured `pe_drain_cycles`==0.
- PE_WAIT: lasts exactly the captured `pe_drain_cycles` cycles, then go to DONE.
- DONE: `done`=1 for one cycle, then go to IDLE.
- Valid tracking:
  - A BUF_DEPTH-stage shift register takes `vb_ifmap_en` at stage 0.
  - `vb_out_valid` is the last stage.
  - The register shifts every cycle in every state.
- `start` outside IDLE is ignored, and the captured config is not modified.
- `rows_sent` holds its final value through IDLE until the next accepted `start`.
- Asynchronous reset assertion at any time returns the block to IDLE with all outputs at their reset values. The in-flight layer is lost and upstream must restart it.

## Timing
- Reset values:
  - state=IDLE.
  - `src_ready`=0, `vb_ifmap_en`=0, `vb_ifmap_in`=0.
  - `vb_out_valid`=0 and the valid shift register all zero.
  - `busy`=0, `done`=0, `rows_sent`=0.
- `vb_ifmap_in` is driven to 0 whenever `vb_ifmap_en`=0.
- Timing from `start`:
  - `start` at cycle t: STREAM and `busy`=1 from t+1.
  - The earliest row is accepted at t+1.
- A row accepted at cycle c:
  - Appears at the buffer output, with `vb_out_valid`=1, at the edge c+BUF_DEPTH.
  - It is visible during cycle c+BUF_DEPTH.
- Layer end:
  - Last row accepted at cycle L: DRAIN occupies L+1 .. L+BUF_DEPTH.
  - PE_WAIT occupies the following D cycles, where D is the captured `pe_drain_cycles`.
  - `done` is high at L+BUF_DEPTH+D+1.
  - `busy` falls in the same cycle as `done`.
- `num_rows`==0: `start` at t gives `done` at t+1; `vb_ifmap_en` is never asserted.
- Back-to-back layers: `start` is legal in the cycle after `done`.
- Minimum full-throughput layer latency is N+BUF_DEPTH+D+1 cycles from `start` to `done`.
- No combinational path from `start` to any output. `src_ready` depends only on state.

## Structure
- A shared package `npu_pkg` holds:
  - `COL_NUM`, `DATA_W` and `BUF_DEPTH` as localparams shared with the vertical buffer and the PE array.
  - The state enum `vbuf_ctrl_state_e`.
- One sub-module, `valid_shreg`: a parameterized BUF_DEPTH-stage 1-bit shift register with asynchronous active-low reset.
- The FSM, the row counter and the drain counters stay in the top module.

## Test plan
- Reset mid-stream: `num_rows`=10, assert reset after 3 rows. Required: all outputs 0 and state IDLE immediately; a new `start` then behaves normally.
- Full-throughput layer: `num_rows`=8, `pe_drain_cycles`=5, `src_valid` held high. Required:
  - `vb_ifmap_en` high for 8 cycles.
  - `vb_out_valid` high for 8 cycles, starting 4 cycles after the first accept.
  - `done` 18 cycles after `start`; `rows_sent`=8.
- Bubbles: `num_rows`=4, `src_valid` pattern 1,0,0,1,1,0,1. Required:
  - `vb_out_valid` reproduces the accepted pattern delayed by 4 cycles.
  - `vb_ifmap_in`=0 in bubble cycles.
  - `rows_sent`=4.
- Zero-config edges:
  - `num_rows`=0 gives `done` one cycle after `start` and no enable.
  - `num_rows`=1 with `pe_drain_cycles`=0 gives `done` 6 cycles after `start`.
- `start` while busy: pulse `start` with `num_rows`=3 during DRAIN of a 2-row layer. Required: ignored; `done` at the original cycle; `rows_sent`=2.
- Back-to-back: pulse `start` the cycle after `done`. Required: the second layer is accepted and `rows_sent` restarts from 0.

Source files
------------

// File: rtl/npu_pkg.sv
// Shared NPU definitions: array geometry used by the vertical buffer, the PE
// array and the feed controller, plus the feed controller state encoding.
package npu_pkg;

   localparam int COL_NUM   = 32;
   localparam int DATA_W    = 8;
   localparam int BUF_DEPTH = 4;

   typedef enum logic [2:0] {
      IDLE,
      STREAM,
      DRAIN,
      PE_WAIT,
      DONE
   } vbuf_ctrl_state_e;

endpackage

// File: rtl/vbuf_feed_ctrl_if.sv
// Row stream into the feed controller and the controller's drive of the
// vertical ifmap buffer. master = row producer / buffer side, slave = controller.
interface vbuf_feed_ctrl_if #(
   parameter int COL_NUM = npu_pkg::COL_NUM,
   parameter int DATA_W  = npu_pkg::DATA_W
);

   logic                             src_valid;
   logic                             src_ready;
   logic [COL_NUM-1:0][DATA_W-1:0]   src_data;
   logic [COL_NUM-1:0][DATA_W-1:0]   vb_ifmap_in;
   logic                             vb_ifmap_en;
   logic                             vb_out_valid;

   modport master (
      output src_valid, src_data,
      input  src_ready, vb_ifmap_in, vb_ifmap_en, vb_out_valid
   );

   modport slave (
      input  src_valid, src_data,
      output src_ready, vb_ifmap_in, vb_ifmap_en, vb_out_valid
   );

endinterface

// File: rtl/vbuf_feed_ctrl_valid_shreg.sv
// DEPTH-stage 1-bit shift register that mirrors the vertical buffer latency,
// so the last stage is high exactly when the buffer output holds a real row.
module valid_shreg #(
   parameter int DEPTH = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic d,
   output logic q
);

   logic [DEPTH-1:0] vld_pipe;

   // shift every cycle, bit 0 is the newest sample
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) vld_pipe <= '0;
      else        vld_pipe <= (vld_pipe << 1) | DEPTH'(d);
   end

   assign q = vld_pipe[DEPTH-1];

endmodule

// File: rtl/vbuf_feed_ctrl.sv
// Feed sequencer for the vertical ifmap buffer: streams one layer of rows into
// the buffer, drains it, waits out the PE latency and pulses done.
module vbuf_feed_ctrl #(
   parameter int COL_NUM   = npu_pkg::COL_NUM,
   parameter int DATA_W    = npu_pkg::DATA_W,
   parameter int BUF_DEPTH = npu_pkg::BUF_DEPTH,
   parameter int ROW_CNT_W = 16,
   parameter int DRAIN_W   = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic [ROW_CNT_W-1:0] num_rows,
   input  logic [DRAIN_W-1:0]   pe_drain_cycles,
   vbuf_feed_ctrl_if.slave      vbuf,
   output logic                 busy,
   output logic                 done,
   output logic [ROW_CNT_W-1:0] rows_sent
);

   import npu_pkg::*;

   localparam int DCW = $clog2(BUF_DEPTH + 1);

   typedef logic [COL_NUM-1:0][DATA_W-1:0] row_t;

   vbuf_ctrl_state_e     state, state_nxt;
   logic [ROW_CNT_W-1:0] num_rows_q;
   logic [DRAIN_W-1:0]   pe_cyc_q;
   logic [DRAIN_W-1:0]   pe_cnt;
   logic [DCW-1:0]       drain_cnt;
   logic                 accept;
   logic                 last_row;

   assign last_row = (rows_sent + ROW_CNT_W'(1)) == num_rows_q;

   // state register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_nxt;
   end

   // next state and state-decoded outputs; start only steers the next state
   always_comb begin
      state_nxt        = state;
      accept           = 1'b0;
      busy             = 1'b0;
      done             = 1'b0;
      vbuf.src_ready   = 1'b0;
      vbuf.vb_ifmap_en = 1'b0;
      case (state)
         IDLE: begin
            if (start) state_nxt = (num_rows == '0) ? DONE : STREAM;
         end
         STREAM: begin
            busy             = 1'b1;
            vbuf.src_ready   = 1'b1;
            accept           = vbuf.src_valid;
            vbuf.vb_ifmap_en = vbuf.src_valid;
            if (vbuf.src_valid && last_row) state_nxt = DRAIN;
         end
         DRAIN: begin
            busy = 1'b1;
            if (drain_cnt == '0) state_nxt = (pe_cyc_q == '0) ? DONE : PE_WAIT;
         end
         PE_WAIT: begin
            busy = 1'b1;
            if (pe_cnt == '0) state_nxt = DONE;
         end
         DONE: begin
            done      = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // bubbles (no enable) shift zeros into the buffer
   always_comb begin
      vbuf.vb_ifmap_in = vbuf.vb_ifmap_en ? row_t'(vbuf.src_data) : row_t'('0);
   end

   // layer config capture and accepted-row count; config frozen outside IDLE
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         num_rows_q <= '0;
         pe_cyc_q   <= '0;
         rows_sent  <= '0;
      end else if (state == IDLE && start) begin
         num_rows_q <= num_rows;
         pe_cyc_q   <= pe_drain_cycles;
         rows_sent  <= '0;
      end else if (accept) begin
         rows_sent  <= rows_sent + ROW_CNT_W'(1);
      end
   end

   // drain and PE-wait down-counters, loaded on entry, expire at zero
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         drain_cnt <= '0;
         pe_cnt    <= '0;
      end else begin
         if (state != DRAIN && state_nxt == DRAIN)
            drain_cnt <= DCW'(BUF_DEPTH - 1);
         else if (state == DRAIN && drain_cnt != '0)
            drain_cnt <= drain_cnt - DCW'(1);

         if (state == DRAIN && state_nxt == PE_WAIT)
            pe_cnt <= pe_cyc_q - DRAIN_W'(1);
         else if (state == PE_WAIT && pe_cnt != '0)
            pe_cnt <= pe_cnt - DRAIN_W'(1);
      end
   end

   valid_shreg #(
      .DEPTH (BUF_DEPTH)
   ) u_valid_shreg (
      .clk   (clk),
      .reset (reset),
      .d     (vbuf.vb_ifmap_en),
      .q     (vbuf.vb_out_valid)
   );

endmodule
